// File: rtl/user_uart_rx.sv
// 8N1 UART receive path: rx synchronizer, mid-bit sampling deserializer and a
// show-ahead receive FIFO with sticky framing-error and overrun flags.
module user_uart_rx #(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          wb_clk_i,
  input  logic                          wb_rst_i,
  input  logic                          rx,
  input  logic [15:0]                   clk_div,
  output logic [7:0]                    rx_data,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          rx_busy,
  output logic                          frame_err,
  output logic                          overrun,
  input  logic                          err_clr,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int          AW         = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL_LEVEL = (AW+1)'(FIFO_DEPTH);
  localparam logic [15:0] MIN_DIV    = 16'd4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_STOP,
    ST_BREAK
  } state_e;

  // Synchronizer
  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   rxs;

  // Deserializer
  state_e      state_q, state_d;
  logic [15:0] div_q, div_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [15:0] div_clamped;
  logic        expired;
  logic        push_req;
  logic        frame_bad;

  // FIFO and flags
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic [7:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] level;
  logic        fifo_empty;
  logic        fifo_full;
  logic        pop;
  logic        do_push;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;

  assign rxs         = sync_q[SYNC_STAGES-1];
  assign div_clamped = (clk_div < MIN_DIV) ? MIN_DIV : clk_div;
  assign expired     = (cnt_q == 16'd1);

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
  end

  // NOTE: every signal assigned in an always_comb gets a default first, so no
  // path through the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    push_req  = 1'b0;
    frame_bad = 1'b0;

    if ((state_q == ST_START || state_q == ST_DATA || state_q == ST_STOP) && !expired) begin
      cnt_d = cnt_q - 16'd1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (!rxs) begin
          div_d   = div_clamped;
          cnt_d   = div_clamped >> 1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (expired) begin
          if (rxs) begin
            // Start bit vanished before its midpoint: line glitch.
            state_d = ST_IDLE;
          end else begin
            cnt_d     = div_q;
            bit_idx_d = 3'd0;
            state_d   = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (expired) begin
          shift_d   = {rxs, shift_q[7:1]};
          cnt_d     = div_q;
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            state_d = ST_STOP;
          end
        end
      end
      ST_STOP: begin
        if (expired) begin
          if (rxs) begin
            push_req = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            frame_bad = 1'b1;
            state_d   = ST_BREAK;
          end
        end
      end
      ST_BREAK: begin
        // A line held low must go high before another start is accepted.
        if (rxs) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign level      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (level == FULL_LEVEL);
  assign pop        = !fifo_empty && rx_ready;
  // A full FIFO still accepts a byte when the head leaves in the same cycle.
  assign do_push    = push_req && (!fifo_full || pop);

  always_comb begin
    wr_ptr_d    = wr_ptr_q + {{AW{1'b0}}, do_push};
    rd_ptr_d    = rd_ptr_q + {{AW{1'b0}}, pop};
    // Clear is applied first so a same-cycle set event wins.
    frame_err_d = (err_clr ? 1'b0 : frame_err_q) | frame_bad;
    overrun_d   = (err_clr ? 1'b0 : overrun_q) | (push_req && fifo_full && !pop);
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every flop samples its _d value from before the edge, independent of order.
  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      sync_q      <= '1;
      state_q     <= ST_IDLE;
      div_q       <= MIN_DIV;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= 8'h00;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      sync_q      <= sync_d;
      state_q     <= state_d;
      div_q       <= div_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  // NOTE: the storage array has no reset; equal pointers mark it empty and the
  // output mux never exposes an unwritten entry.
  always_ff @(posedge wb_clk_i) begin
    if (do_push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= shift_q;
    end
  end

  assign rx_data    = fifo_empty ? 8'h00 : mem_q[rd_ptr_q[AW-1:0]];
  assign rx_valid   = !fifo_empty;
  assign rx_busy    = (state_q != ST_IDLE);
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign fifo_level = level;

endmodule

// File: doc/user_uart_rx.md
# user_uart_rx

Serial receive path of the user-project UART: 8N1 deserializer plus show-ahead receive FIFO. Sits between the `mprj_io[5]` pad (driven by the testbench UART transmitter) and the user-project Wishbone register file, which pops bytes for firmware. Baud rate is runtime-programmable through a clocks-per-bit divisor.

## Interface
Parameters:
- `FIFO_DEPTH`, 8: receive FIFO entries; power of two, at least 2.
- `SYNC_STAGES`, 2: flip-flop stages on `rx` before use; at least 2.

Ports:
- `wb_clk_i`  in  1  clock; all logic on rising edge.
- `wb_rst_i`  in  1  reset, asynchronous, active-high.
- `rx`  in  1  serial input; idle high; asynchronous to `wb_clk_i`.
- `clk_div`  in  16  clocks per bit. Values below 4 are treated as 4.
- `rx_data`  out  8  FIFO head byte; 8'h00 whenever `rx_valid`=0.
- `rx_valid`  out  1  FIFO not empty.
- `rx_ready`  in  1  consumer pop; a pop occurs on a cycle with `rx_valid`&`rx_ready`.
- `rx_busy`  out  1  deserializer not in IDLE.
- `frame_err`  out  1  sticky: a stop bit was sampled low.
- `overrun`  out  1  sticky: a byte was dropped because the FIFO was full.
- `err_clr`  in  1  single-cycle pulse; clears `frame_err` and `overrun`.
- `fifo_level`  out  $clog2(FIFO_DEPTH)+1  current entry count.

## Operation
- `rx` passes through a `SYNC_STAGES` synchronizer. All logic uses only the synchronized bit `rxs`.
- `clk_div` is latched (after the clamp to 4) into `div_q` on start detection. It is held for the whole frame, so mid-frame changes have no effect.
- States:
  - IDLE: on `rxs`=0, latch `div_q`, load bit counter with `div_q>>1`, go to START.
  - START: when the counter expires (mid start bit), sample `rxs`. If 1, treat as a glitch and return to IDLE. If 0, reload the counter with `div_q` and go to DATA with bit index 0.
  - DATA: at each expiry, sample `rxs` into the shift register LSB-first and reload the counter. After bit 7, go to STOP.
  - STOP: at expiry, sample `rxs`.
    - 1: push the byte and return to IDLE.
    - 0: discard the byte, set `frame_err`, go to BREAK.
  - BREAK: wait for `rxs`=1, then go to IDLE. This prevents a held-low line from generating repeated frames.
- Counter: 16-bit down-counter. Expiry is the cycle when it reads 1.
- FIFO: circular buffer with read and write pointers one bit wider than the address.
  - Push when full and no pop in the same cycle: drop the byte, set `overrun`, leave contents unchanged.
  - Push when full with a pop in the same cycle: accept the push, no overrun, level unchanged.
  - Push when empty: byte is visible next cycle. No same-cycle bypass.
  - Pop when empty: ignored.
- Sticky flags: `err_clr` clears both flags. If `err_clr` and a set event occur in the same cycle, set wins.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `rx_busy`=0, `frame_err`=0, `overrun`=0, `fifo_level`=0. State is IDLE, pointers are 0, synchronizer flops are 1.
- Reset asserted mid-frame aborts the frame immediately and discards the partial byte. FIFO contents are lost.
- Latency: `rxs` falls `SYNC_STAGES` cycles after the `rx` falling edge. The push occurs `div_q>>1` + 9·`div_q` cycles after that. `rx_valid` and `fifo_level` update one cycle after the push.
- Back-to-back frames: the deserializer returns to IDLE at mid stop bit, so a start edge arriving a half bit later is caught.
- `rx_busy` is high from the cycle after `rxs` falls in IDLE until the cycle the state returns to IDLE.
- `rx_data`/`rx_valid` change only on push, pop, or reset. The head advances the cycle after a pop.

## Test plan
- `clk_div`=16, send 0xA5 (8N1), `rx_ready`=0 → `rx_valid`=1, `rx_data`=0xA5, `fifo_level`=1, `frame_err`=0. Push occurs 152 cycles after `rxs` falls.
- Drive `rx` low for 6 cycles, then high, `clk_div`=16 → no push, `rx_busy` returns to 0, `fifo_level`=0.
- Send 0x3C with the stop bit low, held low for 40 cycles → no push, `frame_err`=1, remains in BREAK until `rx` goes high. Pulse `err_clr` → `frame_err`=0.
- `FIFO_DEPTH`=8, `rx_ready`=0, send 0x00..0x08 → `fifo_level`=8, `overrun`=1. Popping yields 0x00..0x07, then `rx_valid`=0.
- Assert `wb_rst_i` during DATA bit 4 of 0x77 → all outputs take reset values within the same cycle. A following 0x5A frame is received correctly.
- `clk_div`=4, `rx_ready`=1, frames 0x01 and 0xFF with no idle gap between them → both popped in order, no errors. `clk_div`=2 behaves identically to 4.
